// File: rtl/param_fetch.sv
// Burst-reads up to four ISP parameter words from a 1-cycle-latency RAM and replays them as select strobes.
// Latency: first strobe three cycles after start is accepted; done one cycle after the last strobe.
// Backpressure: none downstream; start is ignored (not queued) while a burst is in progress.
module param_fetch #(
    parameter int ADDR_W = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        load_mask,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    output logic [3:0]        param_sel,
    output logic [31:0]       rd_data,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_q;
    logic [ADDR_W-1:0] base_q;
    logic [3:0]        remain_q;     // enabled entries not yet read
    logic [3:0]        rd_code_q;    // select code travelling with the read in flight
    logic              pipe_vld_q;   // RAM data is valid this cycle
    logic [3:0]        pipe_code_q;

    logic              accept;
    logic [3:0]        src_mask;
    logic [ADDR_W-1:0] src_base;
    logic              nxt_vld;
    logic [1:0]        nxt_idx;
    logic [3:0]        nxt_rest;
    logic [ADDR_W-1:0] nxt_addr;
    logic [3:0]        nxt_code;

    // On the accepting edge the fresh inputs feed the selector so the first read lands in cycle 1.
    assign accept   = (state_q == ST_IDLE) && start;
    assign src_mask = accept ? load_mask : remain_q;
    assign src_base = accept ? base_addr : base_q;

    // Pick the lowest remaining enabled entry; skipped entries cost no cycle.
    always_comb begin
        nxt_vld = 1'b0;
        nxt_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (src_mask[i]) begin
                nxt_vld = 1'b1;
                nxt_idx = 2'(i);
            end
        end
    end

    assign nxt_rest = src_mask & ~(4'b0001 << nxt_idx);
    assign nxt_addr = src_base + ADDR_W'(nxt_idx);
    // Thermometer code: entry 0 -> 0001, 1 -> 0011, 2 -> 0111, 3 -> 1111.
    assign nxt_code = 4'((5'b00010 << nxt_idx) - 5'd1);

    // Burst control: issue one read per cycle, then wait for the pipeline to empty and pulse done.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            remain_q  <= '0;
            rd_code_q <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            done      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        busy   <= 1'b1;
                        if (nxt_vld) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= nxt_addr;
                            rd_code_q <= nxt_code;
                            remain_q  <= nxt_rest;
                            state_q   <= ST_ISSUE;
                        end else begin
                            // Empty mask: nothing to fetch, complete immediately.
                            done    <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (nxt_vld) begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= nxt_addr;
                        rd_code_q <= nxt_code;
                        remain_q  <= nxt_rest;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Last word is on the strobe outputs once the data stage empties.
                    if (!pipe_vld_q) begin
                        done    <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Data path: track the read through RAM latency, then register the word onto the strobe outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pipe_vld_q  <= 1'b0;
            pipe_code_q <= '0;
            param_sel   <= '0;
            rd_data     <= '0;
        end else begin
            pipe_vld_q  <= mem_rd_en;
            pipe_code_q <= rd_code_q;
            param_sel   <= pipe_vld_q ? pipe_code_q : 4'b0000;
            rd_data     <= pipe_vld_q ? mem_rd_data : 32'h0;
        end
    end

endmodule

// File: tb/tb_param_fetch.sv
// Directed bench for param_fetch with a behavioural 1-cycle-latency parameter RAM.
// Cycle k is observed 1 ns after the k-th rising edge following the cycle where start is driven.
// Stimulus is a linear sequence of hand-computed steps.
module tb_param_fetch;

    logic        HCLK;
    logic        HRESETn;
    logic        start;
    logic [7:0]  base_addr;
    logic [3:0]  load_mask;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rd_data;
    logic [3:0]  param_sel;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    logic [31:0] ram [256];

    param_fetch #(.ADDR_W(8)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .start       (start),
        .base_addr   (base_addr),
        .load_mask   (load_mask),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .param_sel   (param_sel),
        .rd_data     (rd_data),
        .busy        (busy),
        .done        (done)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic en, input logic [7:0] addr,
                              input logic [3:0] sel, input logic [31:0] dat,
                              input logic bsy, input logic dn, input logic chk_addr);
        check({tag, ".mem_rd_en"}, {31'h0, mem_rd_en}, {31'h0, en});
        if (chk_addr) check({tag, ".mem_addr"}, {24'h0, mem_addr}, {24'h0, addr});
        check({tag, ".param_sel"}, {28'h0, param_sel}, {28'h0, sel});
        check({tag, ".rd_data"}, rd_data, dat);
        check({tag, ".busy"}, {31'h0, busy}, {31'h0, bsy});
        check({tag, ".done"}, {31'h0, done}, {31'h0, dn});
    endtask

    // Advance one cycle, drop start, check all outputs; address only checked on read cycles.
    task automatic step(input string tag, input logic en, input logic [7:0] addr,
                        input logic [3:0] sel, input logic [31:0] dat,
                        input logic bsy, input logic dn);
        @(posedge HCLK);
        #1;
        start = 1'b0;
        check_outs(tag, en, addr, sel, dat, bsy, dn, en);
    endtask

    task automatic kick(input logic [7:0] base, input logic [3:0] mask);
        base_addr = base;
        load_mask = mask;
        start     = 1'b1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        HRESETn     = 1'b0;
        start       = 1'b0;
        base_addr   = 8'h00;
        load_mask   = 4'h0;
        mem_rd_data = 32'h0;
        for (int i = 0; i < 256; i++) ram[i] = 32'hDEAD0000 | i;
        ram[8'h10] = 32'h11111111;
        ram[8'h11] = 32'h22222222;
        ram[8'h12] = 32'h33333333;
        ram[8'h13] = 32'h44444444;
        ram[8'h21] = 32'hA5A50021;
        ram[8'h23] = 32'h5A5A0023;
        ram[8'hFE] = 32'hCAFE00FE;
        ram[8'hFF] = 32'hBEEF00FF;
        ram[8'h00] = 32'h01234567;
        ram[8'h01] = 32'h89ABCDEF;

        repeat (3) @(posedge HCLK);
        #1;
        check_outs("reset", 1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        step("idle0", 1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0);

        // Full load with ignored starts in cycle 3 and the done cycle; inputs changed mid-burst.
        kick(8'h10, 4'hF);
        step("full.c1", 1'b1, 8'h10, 4'h0, 32'h0, 1'b1, 1'b0);
        step("full.c2", 1'b1, 8'h11, 4'h0, 32'h0, 1'b1, 1'b0);
        step("full.c3", 1'b1, 8'h12, 4'h1, 32'h11111111, 1'b1, 1'b0);
        kick(8'h20, 4'b1010);
        step("full.c4", 1'b1, 8'h13, 4'h3, 32'h22222222, 1'b1, 1'b0);
        step("full.c5", 1'b0, 8'h00, 4'h7, 32'h33333333, 1'b1, 1'b0);
        step("full.c6", 1'b0, 8'h00, 4'hF, 32'h44444444, 1'b1, 1'b0);
        step("full.c7", 1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 1'b1);
        check("full.addr_hold", {24'h0, mem_addr}, 32'h13);
        start = 1'b1;
        step("full.c8", 1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0);

        // Start the cycle after done: sparse burst using the values set mid-burst above.
        start = 1'b1;
        step("sparse.c1", 1'b1, 8'h21, 4'h0, 32'h0, 1'b1, 1'b0);
        step("sparse.c2", 1'b1, 8'h23, 4'h0, 32'h0, 1'b1, 1'b0);
        step("sparse.c3", 1'b0, 8'h00, 4'h3, 32'hA5A50021, 1'b1, 1'b0);
        step("sparse.c4", 1'b0, 8'h00, 4'hF, 32'h5A5A0023, 1'b1, 1'b0);
        step("sparse.c5", 1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 1'b1);
        step("sparse.c6", 1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0);

        // Address wrap.
        kick(8'hFE, 4'hF);
        step("wrap.c1", 1'b1, 8'hFE, 4'h0, 32'h0, 1'b1, 1'b0);
        step("wrap.c2", 1'b1, 8'hFF, 4'h0, 32'h0, 1'b1, 1'b0);
        step("wrap.c3", 1'b1, 8'h00, 4'h1, 32'hCAFE00FE, 1'b1, 1'b0);
        step("wrap.c4", 1'b1, 8'h01, 4'h3, 32'hBEEF00FF, 1'b1, 1'b0);
        step("wrap.c5", 1'b0, 8'h00, 4'h7, 32'h01234567, 1'b1, 1'b0);
        step("wrap.c6", 1'b0, 8'h00, 4'hF, 32'h89ABCDEF, 1'b1, 1'b0);
        step("wrap.c7", 1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 1'b1);
        step("wrap.c8", 1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0);

        // Zero mask: busy and done together in cycle 1 only, no reads.
        kick(8'h40, 4'h0);
        step("zero.c1", 1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 1'b1);
        step("zero.c2", 1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0);
        step("zero.c3", 1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0);

        // Reset in cycle 4 of a full load.
        kick(8'h10, 4'hF);
        step("rst.c1", 1'b1, 8'h10, 4'h0, 32'h0, 1'b1, 1'b0);
        step("rst.c2", 1'b1, 8'h11, 4'h0, 32'h0, 1'b1, 1'b0);
        step("rst.c3", 1'b1, 8'h12, 4'h1, 32'h11111111, 1'b1, 1'b0);
        step("rst.c4", 1'b1, 8'h13, 4'h3, 32'h22222222, 1'b1, 1'b0);
        HRESETn = 1'b0;
        #1;
        check_outs("rst.async", 1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge HCLK);
            #1;
            check_outs("rst.after", 1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        end

        // A fresh start after reset works normally.
        kick(8'h13, 4'b1000);
        step("post.c1", 1'b1, 8'h16, 4'h0, 32'h0, 1'b1, 1'b0);
        step("post.c2", 1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 1'b0);
        step("post.c3", 1'b0, 8'h00, 4'hF, 32'hDEAD0016, 1'b1, 1'b0);
        step("post.c4", 1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 1'b1);
        step("post.c5", 1'b0, 8'h00, 4'h0, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
